// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    localparam int DIV_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } div_state_e;

endpackage

// File: rtl/sub_w.sv
// WIDTH-bit subtractor (a - b) with borrow-out; the only subtractor in the divider.
module sub_w
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    assign {borrow_out, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/seq_divider_ctrl.sv
// Sequential unsigned restoring divider, one quotient bit per cycle, MSB first.
// Optional macro DIV_ZERO_DET_EN: flag divisor=0 at start and skip the iterations.
//
// state | meaning
// IDLE  | waiting for start; results from the last operation held
// RUN   | WIDTH iterations, one quotient bit per cycle
// FIN   | results valid, done pulses for one cycle
module seq_divider_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH:0]   partial;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ge;
    logic             accept;
    logic             zero_skip;

    assign accept  = (state_q == IDLE) && start;
    assign partial = {rem_q, dvd_q[cnt_q]};
    // A set top bit means the shifted partial already exceeds any WIDTH-bit divisor.
    assign ge      = partial[WIDTH] | ~borrow;

    sub_w #(.WIDTH(WIDTH)) u_sub (
        .a          (partial[WIDTH-1:0]),
        .b          (dvs_q),
        .diff       (diff),
        .borrow_out (borrow)
    );

`ifdef DIV_ZERO_DET_EN
    logic err_q;

    assign zero_skip = accept && (divisor == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= zero_skip;
        end
    end

    assign div_err = err_q;
`else
    assign zero_skip = 1'b0;
    assign div_err   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    quo_d   = '0;
                    rem_d   = '0;
                    cnt_d   = CNT_INIT;
                    state_d = RUN;
                    if (zero_skip) begin
                        rem_d   = dividend;
                        state_d = FIN;
                    end
                end
            end
            RUN: begin
                quo_d = {quo_q[WIDTH-2:0], ge};
                rem_d = ge ? diff : partial[WIDTH-1:0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == FIN);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: tb/tb_seq_divider_ctrl.sv
// Scoreboard bench for seq_divider_ctrl: stimulus pushes expected results, a monitor checks them on done.
module tb_seq_divider_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_err;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       err;
        int         done_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    seq_divider_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_err   (div_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Drive start for one cycle; expected done cycle is counted from the cycle start is sampled in.
    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input logic ee,
                         input int lat, input bit track);
        int n;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        n        = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (track) sb.push_back('{eq, er, ee, n + lat});
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while (sb.size() != 0 && i < 40) begin
            @(negedge clk);
            #1;
            i++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 with nothing outstanding (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("quotient",     32'(quotient),  32'(mon_e.q));
                chk("remainder",    32'(remainder), 32'(mon_e.r));
                chk("div_err",      32'(div_err),   32'(mon_e.err));
                chk("done_cycle",   cyc,            mon_e.done_cyc);
                chk("busy_at_done", 32'(busy),      0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy),      0);
        chk("rst_done", 32'(done),      0);
        chk("rst_q",    32'(quotient),  0);
        chk("rst_r",    32'(remainder), 0);
        chk("rst_err",  32'(div_err),   0);
        rst = 1'b0;

        issue(8'd15, 8'd1, 8'd15, 8'd0, 1'b0, 9, 1'b1);
        @(negedge clk);
        chk("busy_run_15_1", 32'(busy), 1);
        wait_drain();

        issue(8'd15, 8'd7, 8'd2, 8'd1, 1'b0, 9, 1'b1);
        wait_drain();
        issue(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9, 1'b1);
        wait_drain();

        issue(8'd170, 8'd85, 8'd2, 8'd0, 1'b0, 9, 1'b1);
        repeat (3) @(negedge clk);
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_mid_run", 32'(busy), 1);
        wait_drain();
        repeat (3) @(negedge clk);
        chk("hold_q_170_85", 32'(quotient),  2);
        chk("hold_r_170_85", 32'(remainder), 0);

`ifdef DIV_ZERO_DET_EN
        issue(8'd200, 8'd0, 8'd0, 8'd200, 1'b1, 1, 1'b1);
        wait_drain();
        repeat (2) @(negedge clk);
        chk("hold_err_200_0", 32'(div_err), 1);
`else
        issue(8'd200, 8'd0, 8'd255, 8'd200, 1'b0, 9, 1'b1);
        wait_drain();
        repeat (2) @(negedge clk);
        chk("hold_q_200_0", 32'(quotient), 255);
`endif

        issue(8'd100, 8'd3, 8'd0, 8'd0, 1'b0, 0, 1'b0);
        chk("clear_q_on_start",   32'(quotient),  0);
        chk("clear_r_on_start",   32'(remainder), 0);
        chk("clear_err_on_start", 32'(div_err),   0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrun_rst_busy", 32'(busy),      0);
        chk("midrun_rst_done", 32'(done),      0);
        chk("midrun_rst_q",    32'(quotient),  0);
        chk("midrun_rst_r",    32'(remainder), 0);
        chk("midrun_rst_err",  32'(div_err),   0);
        @(negedge clk);
        rst = 1'b0;

        issue(8'd100, 8'd3, 8'd33, 8'd1, 1'b0, 9, 1'b1);
        wait_drain();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider_ctrl.md
SEQ_DIVIDER_CTRL -- requirements
Module: seq_divider_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request a new division; sampled only in IDLE.
REQ-005 SHALL have port dividend  input  WIDTH  unsigned dividend; captured on accepted start.
REQ-006 SHALL have port divisor  input  WIDTH  unsigned divisor; captured on accepted start.
REQ-007 SHALL have port busy  output  1  high while an operation is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse when results become valid.
REQ-009 SHALL have port quotient  output  WIDTH  result quotient; held until the next accepted start.
REQ-010 SHALL have port remainder  output  WIDTH  result remainder; held until the next accepted start.
REQ-011 SHALL have port div_err  output  1  divide-by-zero flag; held with the results.

Function
REQ-012 SHALL implement unsigned restoring division, one quotient bit per cycle, MSB first, using one shared WIDTH-bit subtractor (A - B with borrow-out).
REQ-013 SHALL use the FSM states IDLE, RUN, FIN; IDLE->RUN on start, RUN->FIN after WIDTH iterations, FIN->IDLE unconditionally.
REQ-014 SHALL keep a (WIDTH+1)-bit partial remainder; each iteration: shift in next dividend bit; if partial >= divisor, subtract and set the quotient bit to 1; otherwise restore and set it to 0.
REQ-015 SHALL give fixed latency: start accepted at edge N -> busy high from N+1 to N+WIDTH; done=1 and results valid in cycle N+WIDTH+1 (FIN).
REQ-016 SHALL ignore start while busy or in FIN; captured operands SHALL NOT change mid-operation.
REQ-017 SHALL hold quotient/remainder/div_err stable from FIN until the next accepted start, then clear them to 0 at acceptance.
REQ-018 SHALL accept start in IDLE in the cycle immediately after FIN (back-to-back operation).
REQ-019 SHALL, for divisor=0 without the feature in REQ-023, produce quotient=all ones and remainder=dividend with unchanged latency.

Reset
REQ-020 SHALL, on rst=1 at any time including mid-RUN, enter IDLE immediately and drive busy=0, done=0, quotient=0, remainder=0, div_err=0.
REQ-021 SHALL discard any in-flight operation on reset; the first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-022 SHALL be controlled by macro DIV_ZERO_DET_EN.
REQ-023 SHALL, with DIV_ZERO_DET_EN defined, detect divisor=0 at acceptance, skip RUN (IDLE->FIN next cycle, done at N+1), set div_err=1 and drive quotient=0 and remainder=dividend.
REQ-024 SHALL, without DIV_ZERO_DET_EN, tie div_err to 0 and apply REQ-019.

Structure
REQ-025 SHALL place the FSM state enum and the default WIDTH constant in shared package div_pkg.
REQ-026 SHALL instantiate the subtractor as sub-module sub_w (WIDTH parameter; ports a, b, diff, borrow_out); the controller SHALL NOT infer a second subtractor.

Verification
REQ-027 SHALL cover 15/1 (8'b00001111 / 8'b00000001) -> quotient=15, remainder=0, done at N+9.
REQ-028 SHALL cover 15/7 -> quotient=2, remainder=1; then 255/1 back-to-back -> quotient=255, remainder=0.
REQ-029 SHALL cover 170/85 (8'b10101010 / 8'b01010101) -> quotient=2, remainder=0; start pulsed at N+3 is ignored and the results are unchanged.
REQ-030 SHALL cover 200/0 -> with DIV_ZERO_DET_EN: done at N+1, div_err=1, q=0, r=200; without it: done at N+9, q=255, r=200, div_err=0.
REQ-031 SHALL cover rst asserted at N+4 of 100/3 -> all outputs 0 the same cycle; a fresh 100/3 -> quotient=33, remainder=1.
